// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the SRAM round-robin arbiter.
// Configuration macro: SRAM_ARB_STATS_EN (see sram_arbiter.sv).
package sram_arb_pkg;

    // Upper bound on the number of requesters sharing one SRAM.
    localparam int unsigned NUM_REQ_MAX = 8;

    // Width of each per-requester grant statistics counter.
    localparam int unsigned STATS_CNT_W = 16;

    // Next round-robin position after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant from a request vector,
// searching upward from ptr and wrapping modulo N. Holds no state; the
// owner keeps the pointer.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // First active request at or after ptr wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter in front of a single-port SRAM (combinational read,
// synchronous write). One command accepted per cycle; the winner is
// registered onto the SRAM pins (stage A) and read data is registered into a
// shared response bus with a per-requester valid pulse (stage B).
// Optional feature macro: SRAM_ARB_STATS_EN adds stats_clr / grant_cnt.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef SRAM_ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt,
`endif
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_wdata,
    input  logic [DATA_WIDTH-1:0]         sram_rdata
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_check
        $error("sram_arbiter: NUM_REQ=%0d outside 2..%0d", NUM_REQ, NUM_REQ_MAX);
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } arb_cmd_t;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    gnt_raw, grant;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  xfer;
    arb_cmd_t              gnt_cmd, cmd_q, cmd_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]      rd_id_q, rd_id_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt_raw)
    );

    // No grants while reset is held, so nothing is accepted during reset.
    assign grant     = rst_n ? gnt_raw : '0;
    assign req_ready = grant;
    assign xfer      = |grant;

    // Encode the one-hot grant and select the winner's command fields.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
        gnt_cmd.we    = req_we[gnt_idx];
        gnt_cmd.addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_cmd.wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next state: pointer rotation, stage A command, stage B response.
    always_comb begin
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        cmd_d.we    = 1'b0;  // idle cycles keep addr/wdata, never write
        rd_pend_d   = 1'b0;
        rd_id_d     = rd_id_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (xfer) begin
            ptr_d     = PTR_W'(wrap_inc(32'(gnt_idx), NUM_REQ));
            cmd_d     = gnt_cmd;
            rd_pend_d = ~gnt_cmd.we;
            rd_id_d   = gnt_idx;
        end
        if (rd_pend_q) begin
            rsp_valid_d[rd_id_q] = 1'b1;
            rsp_rdata_d          = sram_rdata;
        end
    end

    // State registers; reset also cancels any write sitting on the SRAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            cmd_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cmd_q       <= cmd_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign sram_we    = cmd_q.we;
    assign sram_addr  = cmd_q.addr;
    assign sram_wdata = cmd_q.wdata;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

`ifdef SRAM_ARB_STATS_EN
    logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating per-requester transfer counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (grant[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pack counters into the flat output, slice i for requester i.
    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM, a reference
// memory and a response scoreboard keyed on acceptance order.
module tb_sram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;
`ifdef SRAM_ARB_STATS_EN
    logic            stats_clr;
    logic [N*16-1:0] grant_cnt;
`endif

    sram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SRAM_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM: combinational read, synchronous write.
    logic [DW-1:0] mem [1<<AW];
    logic          mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        end else if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
        end
    end
    assign sram_rdata = mem[sram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [N-1:0] rr_model(input int p, input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (p + k) % N;
            if (v[j]) begin
                r    = '0;
                r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            acc;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] ref_mem [1<<AW];
    int            ptr_m;

    // Monitor: grant model, reference memory, scoreboard push/pop.
    always @(negedge clk) begin
        rsp_t          e;
        logic [AW-1:0] a;
        logic [N-1:0]  exp_g;
        if (!rst_n) begin
            sb.delete();
            ptr_m = 0;
            if (mem_clr) for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        end else begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
                    check("rsp_data", 32'(rsp_rdata), 32'(e.data));
                    check("rsp_latency", cyc, e.acc + 2);
                end
            end
            exp_g = rr_model(ptr_m, req_valid);
            check("grant", 32'(req_ready), 32'(exp_g));
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    a = req_addr[i*AW +: AW];
                    if (req_we[i]) ref_mem[a] = req_wdata[i*DW +: DW];
                    else sb.push_back('{id: i, data: ref_mem[a], acc: cyc});
                    ptr_m = (i + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        logic [N-1:0]  busy;

        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        req_valid = '1;  // must not be granted while in reset
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        tick();
        rst_n     = 1'b1;
        mem_clr   = 1'b0;
        req_valid = '0;

        // Write then read-after-write from the other requester.
        set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        @(negedge clk);
        check("t1_wr_ready", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        check("t1_rd_ready", 32'(req_ready), 32'b10);
        check("t1_sram_we", 32'(sram_we), 32'd1);
        check("t1_sram_addr", 32'(sram_addr), 32'd3);
        check("t1_sram_wdata", 32'(sram_wdata), 32'hA5);
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("t1_rd_we", 32'(sram_we), 32'd0);
        check("t1_rd_addr", 32'(sram_addr), 32'd3);
        tick();
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'b10);
        check("t1_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        tick();

        // Single requester R1 fills addrs 0..5, granted every cycle.
        for (int a = 0; a < 6; a++) begin
            set_req(1, 1'b1, 1'b1, AW'(a), DW'(8'h10 + a));
            @(negedge clk);
            check("t2_single_r1", 32'(req_ready), 32'b10);
            tick();
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);

        // Both requesters contend with reads: grants alternate 0,1,...
        a0 = 4'd0;
        a1 = 4'd1;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 1'b0, a0, 8'h00);
            set_req(1, 1'b1, 1'b0, a1, 8'h00);
            @(negedge clk);
            check("t3_alternate", 32'(req_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
            tick();
            if (k % 2 == 0) a0 = a0 + 4'd2;
            else a1 = a1 + 4'd2;
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        tick();

        // Only R1 for 4 cycles, then R0 wins the next contention.
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b0, AW'(k), 8'h00);
            @(negedge clk);
            check("t4_only_r1", 32'(req_ready), 32'b10);
            tick();
        end
        set_req(0, 1'b1, 1'b0, 4'd7, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd8, 8'h00);
        @(negedge clk);
        check("t4_r0_wins", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("t4_r1_next", 32'(req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (3) tick();

        // Read accepted, then reset pulsed: response must be dropped.
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        check("t5_rd_ready", 32'(req_ready), 32'b01);
        tick();
        rst_n     = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check_reset_outputs();
        tick();
        @(negedge clk);
        check_reset_outputs();
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
        @(negedge clk);
        check("t5_ptr_reset", 32'(req_ready), 32'b01);
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        tick();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);

        // Random mixed traffic; fields held until accepted.
        busy = '0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!busy[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                                DW'($urandom_range(0, 255)));
                        busy[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) busy[i] = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        tick();

`ifdef SRAM_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_req(0, 1'b1, 1'b1, AW'(k), DW'(k));
            tick();
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int k = 0; k < 7; k++) begin
            set_req(1, 1'b1, 1'b1, AW'(k), DW'(k + 100));
            tick();
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("stats_counts", grant_cnt, {16'd7, 16'd20});
        tick();
        stats_clr = 1'b1;
        set_req(0, 1'b1, 1'b1, 4'd0, 8'h00);  // clear beats a same-cycle transfer
        tick();
        stats_clr = 1'b0;
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("stats_clear", grant_cnt, 32'd0);
        tick();
`endif

        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
